// File: rtl/edge_detectors_if.sv
// edge_detectors_if: bundle of the monitored input and detector results.
// master drives a and observes results; slave (the detector) does the reverse.
interface edge_detectors_if #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
);

   logic [WIDTH-1:0]       a;
   logic [WIDTH-1:0]       pos_pulse;
   logic [WIDTH-1:0]       neg_pulse;
   logic [WIDTH-1:0]       both_pulse;
   logic [WIDTH*CNT_W-1:0] pos_count;
   logic [WIDTH*CNT_W-1:0] neg_count;

   modport master (
      output a,
      input  pos_pulse,
      input  neg_pulse,
      input  both_pulse,
      input  pos_count,
      input  neg_count
   );

   modport slave (
      input  a,
      output pos_pulse,
      output neg_pulse,
      output both_pulse,
      output pos_count,
      output neg_count
   );

endinterface

// File: rtl/edge_detectors.sv
// edge_detectors: per-bit rising/falling/any-edge pulses plus saturating
// edge counters, with an optional synchronizer in front.
// Ports:
//   clk   - rising-edge clock
//   rst_n - async active-low reset
//   bus   - slave side: a in; pos/neg/both pulses and counts out.
//           count slice for bit i is [i*CNT_W +: CNT_W].
module edge_detectors #(
   parameter int WIDTH       = 1,
   parameter int SYNC_STAGES = 0,
   parameter int CNT_W       = 8
) (
   input logic           clk,
   input logic           rst_n,
   edge_detectors_if.slave bus
);

   typedef logic [WIDTH-1:0][CNT_W-1:0] cnt_t;

   logic [WIDTH-1:0] a_s;

   logic [WIDTH-1:0] prev_q;
   logic             primed_q;
   logic [WIDTH-1:0] pos_q, pos_d;
   logic [WIDTH-1:0] neg_q, neg_d;
   logic [WIDTH-1:0] both_q, both_d;
   cnt_t             pcnt_q, pcnt_d;
   cnt_t             ncnt_q, ncnt_d;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign a_s = bus.a;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync_q <= '0;
            end else begin
               sync_q[0] <= bus.a;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  sync_q[i] <= sync_q[i-1];
               end
            end
         end

         assign a_s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   // Until primed, prev_q holds the reset value rather than a real
   // sample, so the first edge after reset only captures history.
   always_comb begin
      pos_d  = '0;
      neg_d  = '0;
      both_d = '0;
      if (primed_q) begin
         pos_d  = a_s & ~prev_q;
         neg_d  = ~a_s & prev_q;
         both_d = a_s ^ prev_q;
      end
   end

   // Counters advance on the same edge that registers the pulse.
   always_comb begin
      pcnt_d = pcnt_q;
      ncnt_d = ncnt_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (pos_d[i] && (pcnt_q[i] != '1)) begin
            pcnt_d[i] = pcnt_q[i] + CNT_W'(1);
         end
         if (neg_d[i] && (ncnt_q[i] != '1)) begin
            ncnt_d[i] = ncnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q   <= '0;
         primed_q <= 1'b0;
         pos_q    <= '0;
         neg_q    <= '0;
         both_q   <= '0;
         pcnt_q   <= '0;
         ncnt_q   <= '0;
      end else begin
         prev_q   <= a_s;
         primed_q <= 1'b1;
         pos_q    <= pos_d;
         neg_q    <= neg_d;
         both_q   <= both_d;
         pcnt_q   <= pcnt_d;
         ncnt_q   <= ncnt_d;
      end
   end

   assign bus.pos_pulse  = pos_q;
   assign bus.neg_pulse  = neg_q;
   assign bus.both_pulse = both_q;
   assign bus.pos_count  = pcnt_q;
   assign bus.neg_count  = ncnt_q;

endmodule

// File: tb/tb_edge_detectors.sv
// tb_edge_detectors: scoreboard bench for two detector configurations
// (no synchronizer / 2-bit counters, and 2-stage synchronizer / 8-bit).
`timescale 1ns/1ps
module tb_edge_detectors;

   typedef struct packed {
      logic [3:0]  p;
      logic [3:0]  n;
      logic [3:0]  b;
      logic [31:0] pc;
      logic [31:0] nc;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] a;

   int vecs  = 0;
   int fails = 0;

   exp_t q0[$];
   exp_t q2[$];

   logic [3:0] hist[$];
   int         n;
   int         pcnt[2][4];
   int         ncnt[2][4];

   edge_detectors_if #(.WIDTH(4), .CNT_W(2)) if0 ();
   edge_detectors_if #(.WIDTH(4), .CNT_W(8)) if2 ();

   assign if0.a = a;
   assign if2.a = a;

   edge_detectors #(
      .WIDTH(4), .SYNC_STAGES(0), .CNT_W(2)
   ) u_d0 (
      .clk(clk), .rst_n(rst_n), .bus(if0.slave)
   );

   edge_detectors #(
      .WIDTH(4), .SYNC_STAGES(2), .CNT_W(8)
   ) u_d2 (
      .clk(clk), .rst_n(rst_n), .bus(if2.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [31:0] got,
                        input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
      end
   endtask

   // value seen by the detector at edge k of the current reset epoch
   function automatic logic [3:0] as_at(input int s, input int k);
      if (k - s >= 1) return hist[k-s-1];
      return 4'b0000;
   endfunction

   task automatic predict(input int d, input int s, input int cw,
                          input int maxc, output exp_t e);
      logic [3:0] cur, prv;
      cur = as_at(s, n);
      prv = as_at(s, n - 1);
      e = '0;
      if (n >= 2) begin
         e.p = cur & ~prv;
         e.n = ~cur & prv;
         e.b = cur ^ prv;
      end
      for (int i = 0; i < 4; i++) begin
         if (e.p[i] && pcnt[d][i] < maxc) pcnt[d][i]++;
         if (e.n[i] && ncnt[d][i] < maxc) ncnt[d][i]++;
         e.pc = e.pc | (32'(pcnt[d][i]) << (i * cw));
         e.nc = e.nc | (32'(ncnt[d][i]) << (i * cw));
      end
   endtask

   task automatic model_reset();
      n = 0;
      hist.delete();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 4; i++) begin
            pcnt[d][i] = 0;
            ncnt[d][i] = 0;
         end
   endtask

   // drive one vector at a negedge, queue the result expected after
   // the next rising edge, optionally glitch a between edges
   task automatic apply(input logic [3:0] v, input bit glitch);
      exp_t e;
      a = v;
      n++;
      hist.push_back(v);
      predict(0, 0, 2, 3, e);
      q0.push_back(e);
      predict(1, 2, 8, 255, e);
      q2.push_back(e);
      if (glitch) begin
         #1 a = ~v;
         #1 a = v;
      end
      @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".d0.pos"}, 32'(if0.pos_pulse), 32'd0);
      check({tag, ".d0.neg"}, 32'(if0.neg_pulse), 32'd0);
      check({tag, ".d0.both"}, 32'(if0.both_pulse), 32'd0);
      check({tag, ".d0.pc"}, 32'(if0.pos_count), 32'd0);
      check({tag, ".d0.nc"}, 32'(if0.neg_count), 32'd0);
      check({tag, ".d2.pos"}, 32'(if2.pos_pulse), 32'd0);
      check({tag, ".d2.neg"}, 32'(if2.neg_pulse), 32'd0);
      check({tag, ".d2.both"}, 32'(if2.both_pulse), 32'd0);
      check({tag, ".d2.pc"}, 32'(if2.pos_count), 32'd0);
      check({tag, ".d2.nc"}, 32'(if2.neg_count), 32'd0);
   endtask

   // monitor: outputs are valid every cycle once a vector is in flight
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q0.size() > 0) begin
            e = q0.pop_front();
            check("d0.pos", 32'(if0.pos_pulse), 32'(e.p));
            check("d0.neg", 32'(if0.neg_pulse), 32'(e.n));
            check("d0.both", 32'(if0.both_pulse), 32'(e.b));
            check("d0.pc", 32'(if0.pos_count), e.pc);
            check("d0.nc", 32'(if0.neg_count), e.nc);
         end
         if (q2.size() > 0) begin
            e = q2.pop_front();
            check("d2.pos", 32'(if2.pos_pulse), 32'(e.p));
            check("d2.neg", 32'(if2.neg_pulse), 32'(e.n));
            check("d2.both", 32'(if2.both_pulse), 32'(e.b));
            check("d2.pc", 32'(if2.pos_count), e.pc);
            check("d2.nc", 32'(if2.neg_count), e.nc);
         end
      end
   end

   initial begin
      int k;
      a     = 4'b0000;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_zero("rst");

      // segment 1: toggles, steady levels, glitch, saturation
      rst_n = 1'b1;
      apply(4'b0000, 1'b0);
      apply(4'b0001, 1'b0);
      apply(4'b0000, 1'b0);
      apply(4'b0001, 1'b0);
      apply(4'b0000, 1'b0);
      apply(4'b0101, 1'b0);
      apply(4'b1010, 1'b0);
      apply(4'b1010, 1'b1);
      apply(4'b1111, 1'b0);
      apply(4'b0000, 1'b0);
      apply(4'b1111, 1'b0);
      apply(4'b1111, 1'b0);
      apply(4'b1111, 1'b0);

      // hand-computed totals (d0 saturates at 3)
      check("d0.pc.total", 32'(if0.pos_count), 32'h0000_00BB);
      check("d0.nc.total", 32'(if0.neg_count), 32'h0000_0067);
      check("d2.pc.total", 32'(if2.pos_count), 32'h0203_0205);
      check("d2.nc.total", 32'(if2.neg_count), 32'h0102_0104);

      // segment 2: reset mid-count, a held high through release
      a     = 4'b1111;
      rst_n = 1'b0;
      #1;
      check_zero("rst_cnt");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      apply(4'b1111, 1'b0);
      apply(4'b1111, 1'b0);
      apply(4'b1111, 1'b0);
      apply(4'b1110, 1'b0);
      apply(4'b1110, 1'b0);
      apply(4'b1110, 1'b0);
      apply(4'b1110, 1'b0);

      // segment 3: reset while a pulse is high
      rst_n = 1'b0;
      a     = 4'b0000;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      apply(4'b0000, 1'b0);
      apply(4'b0011, 1'b0);
      check("d0.pos.held", 32'(if0.pos_pulse), 32'h3);
      #1 rst_n = 1'b0;
      #1;
      check_zero("rst_pulse");
      model_reset();

      k = 0;
      while ((q0.size() > 0 || q2.size() > 0) && k < 10) begin
         @(negedge clk);
         k++;
      end
      check("drain", 32'(q0.size() + q2.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule

// File: doc/edge_detectors.md
EDGE_DETECTORS -- requirements
Module: edge_detectors

Interface
REQ-001 Parameter WIDTH, default 1: number of independent input bits monitored; legal range 1-32.
REQ-002 Parameter SYNC_STAGES, default 0: synchronizer flops in front of the detector; 0 = no synchronizer, legal range 0-3.
REQ-003 Parameter CNT_W, default 8: width of each per-bit edge counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 a  input  WIDTH  monitored signal(s); may be asynchronous when SYNC_STAGES>0.
REQ-007 pos_pulse  output  WIDTH  per-bit one-cycle pulse on a 0->1 transition.
REQ-008 neg_pulse  output  WIDTH  per-bit one-cycle pulse on a 1->0 transition.
REQ-009 both_pulse  output  WIDTH  per-bit one-cycle pulse on either transition.
REQ-010 pos_count  output  WIDTH*CNT_W  per-bit saturating count of rising edges; bit i uses slice [i*CNT_W +: CNT_W].
REQ-011 neg_count  output  WIDTH*CNT_W  per-bit saturating count of falling edges; same slicing as pos_count.

Function
REQ-012 The block SHALL compute a_s, the input delayed by SYNC_STAGES register stages; a_s SHALL equal a directly when SYNC_STAGES=0.
REQ-013 The block SHALL keep a history register prev holding a_s from the previous rising clk edge.
REQ-014 At each rising clk edge, each bit SHALL register pos_pulse <= a_s & ~prev, neg_pulse <= ~a_s & prev, and both_pulse <= a_s ^ prev, then update prev <= a_s.
REQ-015 All outputs SHALL be registered; no combinational path SHALL exist from a to any output.
REQ-016 Latency: a change on a that is stable before clk edge k SHALL produce a pulse high from edge k+SYNC_STAGES to edge k+SYNC_STAGES+1.
REQ-017 Each pulse SHALL last exactly one clk cycle per detected transition.
REQ-018 A steady input level SHALL never produce a pulse.
REQ-019 For every bit and every cycle, both_pulse SHALL equal pos_pulse | neg_pulse, and pos_pulse & neg_pulse SHALL be 0.
REQ-020 If a toggles and returns between two clk edges, no pulse SHALL be required.
REQ-021 If a toggles every cycle, the corresponding pulse SHALL be asserted every cycle, alternating between pos_pulse and neg_pulse.
REQ-022 A bit's counter SHALL increment by 1 in the same cycle its pos_pulse or neg_pulse is registered high.
REQ-023 Each counter SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-024 Bits SHALL be fully independent; simultaneous edges on several bits SHALL each produce their own pulses and counts.

Reset
REQ-025 While rst_n=0, all of the following SHALL be forced to 0 asynchronously: pos_pulse, neg_pulse, both_pulse, pos_count, neg_count, prev, synchronizer flops.
REQ-026 A flag primed SHALL reset to 0.
REQ-027 On the first rising clk edge after rst_n deasserts, the block SHALL load prev from a_s, set primed, and emit no pulse.
REQ-028 Detection SHALL start from the second rising clk edge after rst_n deasserts.
REQ-029 Because of REQ-027, an input held at 1 through reset release SHALL NOT produce a spurious rising edge.
REQ-030 Asserting rst_n mid-pulse SHALL clear the pulse immediately.
REQ-031 Asserting rst_n mid-count SHALL clear the counters immediately.

Verification
REQ-032 Default params, clk period 10 ns, reset released before t=0, a rises at 3 ns -> pos_pulse=1 and both_pulse=1 for 5-15 ns, neg_pulse=0.
REQ-033 Continuing, a falls at 13 ns, rises at 23 ns, falls at 33 ns -> neg_pulse high 15-25 ns, pos_pulse high 25-35 ns, neg_pulse high 35-45 ns, both_pulse high continuously 5-45 ns, pos_count=2, neg_count=2.
REQ-034 Hold a=1 through reset release -> no pulse, counters stay 0; a then falls -> one neg_pulse.
REQ-035 Drop rst_n while pos_pulse=1 -> all outputs 0 immediately, before the next clk edge.
REQ-036 CNT_W=2, 5 rising edges -> pos_count stops at 3.
REQ-037 WIDTH=4, SYNC_STAGES=2, a=4'b0101->4'b1010 -> pos_pulse=4'b1010 and neg_pulse=4'b0101 two cycles later than with SYNC_STAGES=0.
